// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the fetch front end.
// Holds the fetch FSM encoding and common constants.
package cpu_defs_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2,
        FAULT = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: one held imem read per PC,
// buffered result handed downstream with valid/ready.
module ifetch_ctrl
    import cpu_defs_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              fetch_en_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [31:0]       imem_rdata_i,
    output logic [31:0]       inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic              pc_we_o,
    output logic              misalign_o
);

    fetch_state_e      state_q;
    logic              req_q;
    logic              valid_q;
    logic              fault_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] inst_pc_q;
    logic [31:0]       inst_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
            pc_q      <= '0;
            inst_pc_q <= '0;
            inst_q    <= NOP_INST;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (fetch_en_i) begin
                        if (pc_i[1:0] == 2'b00) begin
                            state_q <= REQ;
                            req_q   <= 1'b1;
                            pc_q    <= pc_i;
                        end else begin
                            state_q <= FAULT;
                            fault_q <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    // Request stays up until ack; fetch_en_i is ignored here.
                    if (imem_ack_i) begin
                        state_q   <= VALID;
                        req_q     <= 1'b0;
                        valid_q   <= 1'b1;
                        inst_q    <= imem_rdata_i;
                        inst_pc_q <= pc_q;
                    end
                end
                VALID: begin
                    if (inst_ready_i) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                FAULT: begin
                    state_q <= FAULT;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign imem_req_o   = req_q;
    assign imem_addr_o  = {pc_q[ADDR_W-1:2], 2'b00};
    assign inst_valid_o = valid_q;
    assign inst_o       = valid_q ? inst_q : NOP_INST;
    assign inst_pc_o    = inst_pc_q;
    assign pc_we_o      = valid_q & inst_ready_i;
    assign misalign_o   = fault_q;

endmodule

// File: doc/ifetch_ctrl.md
# ifetch_ctrl

Instruction-fetch controller that sits between the PC register and the instruction memory. It takes the current PC and issues a held request/acknowledge read to instruction memory. It buffers the returned word and hands it downstream with a valid/ready handshake. It also pulses the write-enable that lets the PC register advance to the next PC, so the PC changes only after an instruction has actually been consumed.

## Interface
Parameters:
- ADDR_W, 32, PC / instruction-memory address width
- NOP_INST, 32'h0000_0013, value driven on inst_o whenever inst_valid_o is low

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- reset_i  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high)
- pc_i  in  ADDR_W  current PC from the PC register
- fetch_en_i  in  1  permission to start a new fetch
- imem_req_o  out  1  read request to instruction memory
- imem_addr_o  out  ADDR_W  read address; {pc[ADDR_W-1:2],2'b00}
- imem_ack_i  in  1  memory has data on imem_rdata_i this cycle
- imem_rdata_i  in  32  instruction word
- inst_o  out  32  buffered instruction
- inst_pc_o  out  ADDR_W  PC of inst_o
- inst_valid_o  out  1  inst_o/inst_pc_o valid
- inst_ready_i  in  1  downstream accepts instruction
- pc_we_o  out  1  PC register may load next PC (combinational: inst_valid_o & inst_ready_i)
- misalign_o  out  1  sticky fault, pc_i[1:0] != 0 at fetch start

## Operation
- FSM states: IDLE, REQ, VALID, FAULT.
- IDLE:
  - fetch_en_i=1 and pc_i[1:0]==0 → REQ; latch pc_i into the address/PC register.
  - fetch_en_i=1 and pc_i[1:0]!=0 → FAULT.
  - Otherwise stay in IDLE.
- REQ:
  - imem_req_o=1; imem_addr_o holds the latched PC, stable until ack.
  - imem_ack_i=1 → capture imem_rdata_i into inst_o; go to VALID.
  - imem_ack_i=0 → stay in REQ.
  - A request is never withdrawn: fetch_en_i falling during REQ has no effect.
- VALID:
  - inst_valid_o=1; inst_o/inst_pc_o stay stable until accepted.
  - inst_ready_i=1 → pc_we_o=1 for that cycle; go to IDLE.
- FAULT:
  - misalign_o=1; no requests issued, inst_valid_o=0.
  - Exit only via reset_i.
- imem_ack_i outside REQ is ignored; imem_rdata_i is not sampled.
- pc_i is sampled only on the IDLE→REQ transition. Changes to pc_i at other times have no effect.
- No arithmetic. Address alignment check is on pc_i[1:0] only.

## Timing
- Reset values: state IDLE, imem_req_o=0, imem_addr_o=0, inst_o=NOP_INST, inst_pc_o=0, inst_valid_o=0, pc_we_o=0, misalign_o=0.
- reset_i overrides everything. Asserted mid-REQ, imem_req_o is low the cycle after the reset edge, and a late ack is ignored.
- Zero-wait memory (ack in the first REQ cycle), always-ready consumer:
  - cycle 0: IDLE, fetch_en_i=1
  - cycle 1: REQ
  - cycle 2: VALID + pc_we_o
  - cycle 3: IDLE, with the new pc_i visible
  - Throughput is one instruction per 3 cycles.
- Each memory wait cycle adds one cycle in REQ. Each cycle with inst_ready_i low adds one cycle in VALID.
- pc_we_o is high for exactly one cycle per accepted instruction, never in any other state.
- Simultaneous reset_i and imem_ack_i: reset wins; no data is captured.

## Structure
- Shared package cpu_defs_pkg: fetch FSM state enum (IDLE/REQ/VALID/FAULT), NOP_INST constant, ADDR_W default.
- Single module with no sub-modules.
- One registered FSM plus a capture register for inst_o/inst_pc_o. pc_we_o is combinational from state and inst_ready_i.

## Test plan
- Reset then idle: reset_i 1 cycle, fetch_en_i=0 for 10 cycles → imem_req_o=0, inst_valid_o=0, inst_o=32'h13 throughout.
- Zero-wait fetch: pc_i=0, fetch_en_i=1, ack in the first REQ cycle with rdata=32'h00500093, inst_ready_i=1 → imem_addr_o=0. Next cycle inst_valid_o=1, inst_o=32'h00500093, inst_pc_o=0, pc_we_o=1 for exactly 1 cycle.
- Wait states and backpressure: pc_i=32'h4, ack delayed 3 cycles, inst_ready_i low 2 cycles → imem_req_o high for 4 cycles with addr=32'h4 stable. inst_valid_o high for 3 cycles with data stable; one pc_we_o pulse.
- Misaligned PC: pc_i=32'h6, fetch_en_i=1 → misalign_o=1 from the next cycle and stays high, no imem_req_o ever. Reset clears it.
- Reset mid-request: reset_i in the second REQ cycle, ack arriving the cycle after → imem_req_o=0 and inst_valid_o=0 after the edge; ack ignored, inst_o=32'h13.
- Spurious ack in IDLE and pc_i change while in VALID → no capture, no state change; inst_pc_o keeps the PC latched at fetch start.
